// File: rtl/dafx_amplitude_tracker.sv
// Signed ADC amplitude tracker: min/max since last clear, min/max per fixed
// sample window, and a sticky clip interrupt on a programmable magnitude.
module dafx_amplitude_tracker #(
  parameter int AUDIO_WIDTH_P   = 24,
  parameter int WINDOW_LENGTH_P = 48000,
  parameter int WIN_CNT_WIDTH_P = $clog2(WINDOW_LENGTH_P)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [AUDIO_WIDTH_P-1:0] x_data,
  input  logic                     cmd_clear_amplitude,
  input  logic                     cmd_clear_irq,
  input  logic [AUDIO_WIDTH_P-1:0] cr_clip_threshold,
  output logic [AUDIO_WIDTH_P-1:0] sr_min_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_max_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_win_min_amplitude,
  output logic [AUDIO_WIDTH_P-1:0] sr_win_max_amplitude,
  output logic                     win_done,
  output logic                     irq_clip,
  output logic                     fsm_state
);

  // Handshake: a sample transfers on any cycle where x_valid && x_ready.
  // x_ready is registered, held at 1 out of reset, and never deasserts.

  localparam int W = AUDIO_WIDTH_P;
  localparam logic [WIN_CNT_WIDTH_P-1:0] WIN_LAST = WIN_CNT_WIDTH_P'(WINDOW_LENGTH_P - 1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_TRACK = 1'b1} state_t;

  state_t                     state_q;
  logic [WIN_CNT_WIDTH_P-1:0] win_cnt;
  logic signed [W-1:0]        min_q, max_q;
  logic signed [W-1:0]        win_min, win_max;
  logic signed [W-1:0]        win_min_pub, win_max_pub;

  logic                       accept;
  logic signed [W-1:0]        sample;
  logic                       seed;
  logic                       win_seed;
  logic                       win_last;
  logic [WIN_CNT_WIDTH_P-1:0] win_cnt_base;
  logic signed [W-1:0]        win_min_next, win_max_next;
  logic [W:0]                 mag;
  logic                       clip_hit;

  assign accept = x_valid && x_ready;
  assign sample = x_data;

  // A clear in the same cycle as an accept restarts tracking with that sample.
  assign seed         = cmd_clear_amplitude || (state_q == ST_EMPTY);
  assign win_seed     = cmd_clear_amplitude || (win_cnt == '0);
  assign win_last     = !cmd_clear_amplitude && (win_cnt == WIN_LAST);
  assign win_cnt_base = cmd_clear_amplitude ? '0 : win_cnt;

  assign win_min_next = win_seed ? sample : ((sample < win_min) ? sample : win_min);
  assign win_max_next = win_seed ? sample : ((sample > win_max) ? sample : win_max);

  // One extra bit so the most negative sample has a representable magnitude.
  assign mag      = x_data[W-1] ? ({1'b0, ~x_data} + (W+1)'(1)) : {1'b0, x_data};
  assign clip_hit = accept && (cr_clip_threshold != '0) && (mag >= {1'b0, cr_clip_threshold});

  always_ff @(posedge clk) begin
    if (rst) begin
      x_ready     <= 1'b1;
      state_q     <= ST_EMPTY;
      win_cnt     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      win_min     <= '0;
      win_max     <= '0;
      win_min_pub <= '0;
      win_max_pub <= '0;
      win_done    <= 1'b0;
      irq_clip    <= 1'b0;
    end else begin
      x_ready  <= 1'b1;
      win_done <= 1'b0;

      if (cmd_clear_amplitude) begin
        min_q   <= '0;
        max_q   <= '0;
        state_q <= ST_EMPTY;
        win_cnt <= '0;
      end

      if (accept) begin
        if (seed) begin
          min_q <= sample;
          max_q <= sample;
        end else begin
          if (sample < min_q) min_q <= sample;
          if (sample > max_q) max_q <= sample;
        end
        state_q <= ST_TRACK;

        win_min <= win_min_next;
        win_max <= win_max_next;
        if (win_last) begin
          win_min_pub <= win_min_next;
          win_max_pub <= win_max_next;
          win_done    <= 1'b1;
          win_cnt     <= '0;
        end else begin
          win_cnt <= win_cnt_base + WIN_CNT_WIDTH_P'(1);
        end
      end

      // Set has priority over a coincident clear.
      if (clip_hit) begin
        irq_clip <= 1'b1;
      end else if (cmd_clear_irq) begin
        irq_clip <= 1'b0;
      end
    end
  end

  assign sr_min_amplitude     = min_q;
  assign sr_max_amplitude     = max_q;
  assign sr_win_min_amplitude = win_min_pub;
  assign sr_win_max_amplitude = win_max_pub;
  assign fsm_state            = state_q;

endmodule
